// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship game-flow controller.
package battleship_pkg;

    typedef enum logic [2:0] {
        SEL     = 3'd0,
        PLACE   = 3'd1,
        P_TURN  = 3'd2,
        P_CHK   = 3'd3,
        PC_TURN = 3'd4,
        PC_CHK  = 3'd5,
        OVER    = 3'd6
    } state_t;

    localparam logic WIN_PLAYER = 1'b0;
    localparam logic WIN_PC     = 1'b1;

    function automatic int clamp_ships(input int req, input int max_ships);
        if (req < 1)
            return 1;
        if (req > max_ships)
            return max_ships;
        return req;
    endfunction

endpackage

// File: rtl/battleship_turn_ctrl_if.sv
// Front-end / board-datapath signal bundle of the turn controller.
interface battleship_turn_ctrl_if #(
    parameter int TURN_CYCLES    = 750_000_000,
    parameter int MAX_SHIPS      = 5,
    parameter int SHOTS_PER_TURN = 1
);
    localparam int TW = $clog2(TURN_CYCLES);
    localparam int SW = $clog2(MAX_SHIPS + 1);
    localparam int KW = $clog2(SHOTS_PER_TURN + 1);

    logic          btn;
    logic [SW-1:0] n_ships_in;
    logic          place_ok;
    logic          shot_valid;
    logic          shot_sunk;

    logic          sel_ships;
    logic          place_en;
    logic          player_turn;
    logic          chk_player;
    logic          pc_fire;
    logic          chk_pc;
    logic          timer_en;
    logic [TW-1:0] time_left;
    logic [SW-1:0] n_ships;
    logic [SW-1:0] ships_left;
    logic [KW-1:0] shots_left;
    logic [SW-1:0] p_sunk;
    logic [SW-1:0] pc_sunk;
    logic          game_over;
    logic          winner;
    logic          pc_error;

    modport master (
        input  btn, n_ships_in, place_ok, shot_valid, shot_sunk,
        output sel_ships, place_en, player_turn, chk_player, pc_fire, chk_pc,
               timer_en, time_left, n_ships, ships_left, shots_left,
               p_sunk, pc_sunk, game_over, winner, pc_error
    );

    modport slave (
        output btn, n_ships_in, place_ok, shot_valid, shot_sunk,
        input  sel_ships, place_en, player_turn, chk_player, pc_fire, chk_pc,
               timer_en, time_left, n_ships, ships_left, shots_left,
               p_sunk, pc_sunk, game_over, winner, pc_error
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button plus rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pe
);

    // [0],[1] synchronise; [2] holds the previous synchronised level
    logic [2:0] sh_q, sh_d;

    always_comb sh_d = {sh_q[1:0], btn_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign btn_pe = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/battleship_turn_ctrl.sv
// Battleship game-flow controller: selection, placement, timed player turns,
// PC turns with bounded retries, sunk-ship win tracking and restart.
//   state   | meaning
//   SEL     | choose fleet size, wait for btn
//   PLACE   | count legal player placements
//   P_TURN  | player aiming, turn timer running
//   P_CHK   | player shot evaluated
//   PC_TURN | PC target request
//   PC_CHK  | PC shot evaluated
//   OVER    | game ended, wait for btn to restart
module battleship_turn_ctrl
    import battleship_pkg::*;
#(
    parameter int TURN_CYCLES    = 750_000_000,
    parameter int MAX_SHIPS      = 5,
    parameter int SHOTS_PER_TURN = 1,
    parameter int PC_RETRY_MAX   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    battleship_turn_ctrl_if.master bus
);

    localparam int TW = $clog2(TURN_CYCLES);
    localparam int SW = $clog2(MAX_SHIPS + 1);
    localparam int KW = $clog2(SHOTS_PER_TURN + 1);
    localparam int RW = $clog2(PC_RETRY_MAX + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] time_left_q, time_left_d;
    logic [SW-1:0] n_ships_q, n_ships_d;
    logic [SW-1:0] ships_left_q, ships_left_d;
    logic [KW-1:0] shots_left_q, shots_left_d;
    logic [SW-1:0] p_sunk_q, p_sunk_d;
    logic [SW-1:0] pc_sunk_q, pc_sunk_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          winner_q, winner_d;
    logic          pc_error_q, pc_error_d;

    logic          btn_pe;
    logic          load_turn, pc_entry;
    logic [SW-1:0] ships_dec, p_sunk_inc, pc_sunk_inc, clamped;
    logic [KW-1:0] shots_dec;
    logic [RW-1:0] retry_inc;

    btn_edge_sync u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(bus.btn),
        .btn_pe (btn_pe)
    );

    // Saturating step values; counters never wrap
    assign ships_dec   = (ships_left_q == '0) ? '0 : ships_left_q - SW'(1);
    assign shots_dec   = (shots_left_q == '0) ? '0 : shots_left_q - KW'(1);
    assign p_sunk_inc  = (p_sunk_q  == '1) ? p_sunk_q  : p_sunk_q  + SW'(bus.shot_sunk);
    assign pc_sunk_inc = (pc_sunk_q == '1) ? pc_sunk_q : pc_sunk_q + SW'(bus.shot_sunk);
    assign retry_inc   = (retry_q   == '1) ? retry_q   : retry_q   + RW'(1);
    assign clamped     = SW'(clamp_ships(int'(bus.n_ships_in), MAX_SHIPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEL;
            time_left_q  <= '0;
            n_ships_q    <= SW'(1);
            ships_left_q <= '0;
            shots_left_q <= '0;
            p_sunk_q     <= '0;
            pc_sunk_q    <= '0;
            retry_q      <= '0;
            winner_q     <= 1'b0;
            pc_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_left_q  <= time_left_d;
            n_ships_q    <= n_ships_d;
            ships_left_q <= ships_left_d;
            shots_left_q <= shots_left_d;
            p_sunk_q     <= p_sunk_d;
            pc_sunk_q    <= pc_sunk_d;
            retry_q      <= retry_d;
            winner_q     <= winner_d;
            pc_error_q   <= pc_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        time_left_d  = time_left_q;
        n_ships_d    = n_ships_q;
        ships_left_d = ships_left_q;
        shots_left_d = shots_left_q;
        p_sunk_d     = p_sunk_q;
        pc_sunk_d    = pc_sunk_q;
        retry_d      = retry_q;
        winner_d     = winner_q;
        pc_error_d   = pc_error_q;
        load_turn    = 1'b0;
        pc_entry     = 1'b0;

        case (state_q)
            SEL: if (btn_pe) begin
                n_ships_d    = clamped;
                ships_left_d = clamped;
                state_d      = PLACE;
            end
            PLACE: if (bus.place_ok) begin
                ships_left_d = ships_dec;
                if (ships_left_q == SW'(1)) begin
                    state_d   = P_TURN;
                    load_turn = 1'b1;
                end
            end
            // btn beats a simultaneous timeout
            P_TURN: begin
                if (btn_pe)
                    state_d = P_CHK;
                else if (time_left_q == '0) begin
                    state_d  = PC_TURN;
                    pc_entry = 1'b1;
                end else
                    time_left_d = time_left_q - TW'(1);
            end
            P_CHK: begin
                state_d = P_TURN;
                if (bus.shot_valid) begin
                    shots_left_d = shots_dec;
                    p_sunk_d     = p_sunk_inc;
                    if (p_sunk_inc == n_ships_q) begin
                        state_d  = OVER;
                        winner_d = WIN_PLAYER;
                    end else if (shots_dec == '0) begin
                        state_d  = PC_TURN;
                        pc_entry = 1'b1;
                    end
                end
            end
            PC_TURN: state_d = PC_CHK;
            PC_CHK: begin
                state_d = PC_TURN;
                if (bus.shot_valid) begin
                    retry_d      = '0;
                    shots_left_d = shots_dec;
                    pc_sunk_d    = pc_sunk_inc;
                    if (pc_sunk_inc == n_ships_q) begin
                        state_d  = OVER;
                        winner_d = WIN_PC;
                    end else if (shots_dec == '0) begin
                        state_d   = P_TURN;
                        load_turn = 1'b1;
                    end
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc == RW'(PC_RETRY_MAX)) begin
                        pc_error_d = 1'b1;
                        state_d    = P_TURN;
                        load_turn  = 1'b1;
                    end
                end
            end
            OVER: if (btn_pe) begin
                state_d    = SEL;
                p_sunk_d   = '0;
                pc_sunk_d  = '0;
                pc_error_d = 1'b0;
                winner_d   = 1'b0;
            end
            default: state_d = SEL;
        endcase

        if (load_turn) begin
            time_left_d  = TW'(TURN_CYCLES - 1);
            shots_left_d = KW'(SHOTS_PER_TURN);
        end
        if (pc_entry) begin
            shots_left_d = KW'(SHOTS_PER_TURN);
            retry_d      = '0;
        end
    end

    always_comb begin
        bus.sel_ships   = (state_q == SEL);
        bus.place_en    = (state_q == PLACE);
        bus.player_turn = (state_q == P_TURN);
        bus.timer_en    = (state_q == P_TURN);
        bus.chk_player  = (state_q == P_CHK);
        bus.pc_fire     = (state_q == PC_TURN);
        bus.chk_pc      = (state_q == PC_CHK);
        bus.game_over   = (state_q == OVER);
        bus.time_left   = time_left_q;
        bus.n_ships     = n_ships_q;
        bus.ships_left  = ships_left_q;
        bus.shots_left  = shots_left_q;
        bus.p_sunk      = p_sunk_q;
        bus.pc_sunk     = pc_sunk_q;
        bus.winner      = winner_q;
        bus.pc_error    = pc_error_q;
    end

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed table-driven bench for battleship_turn_ctrl.
`timescale 1ns/1ps
module tb_battleship_turn_ctrl;
    import battleship_pkg::*;

    typedef enum int {OP_TICK, OP_BTN, OP_PLC, OP_RST} op_t;

    typedef struct {
        op_t    op;
        int     rep;
        int     nin;
        bit     sv;
        bit     sk;
        state_t st;
        int     tl, sl, kl, ns, ps, pcs;
        bit     err, win;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    battleship_turn_ctrl_if #(.TURN_CYCLES(8), .MAX_SHIPS(5), .SHOTS_PER_TURN(2)) bus ();

    battleship_turn_ctrl #(
        .TURN_CYCLES(8), .MAX_SHIPS(5), .SHOTS_PER_TURN(2), .PC_RETRY_MAX(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_flags(input state_t s);
        case (s)
            SEL:     return 8'b1000_0000;
            PLACE:   return 8'b0100_0000;
            P_TURN:  return 8'b0010_0010;
            P_CHK:   return 8'b0001_0000;
            PC_TURN: return 8'b0000_1000;
            PC_CHK:  return 8'b0000_0100;
            OVER:    return 8'b0000_0001;
            default: return 0;
        endcase
    endfunction

    function automatic int act_flags();
        return int'({bus.sel_ships, bus.place_en, bus.player_turn, bus.chk_player,
                     bus.pc_fire, bus.chk_pc, bus.timer_en, bus.game_over});
    endfunction

    function automatic vec_t mk(input op_t op, input int rep, input int nin, input bit sv,
                                input bit sk, input state_t st, input int tl, input int sl,
                                input int kl, input int ns, input int ps, input int pcs,
                                input bit err, input bit win);
        vec_t v;
        v.op = op; v.rep = rep; v.nin = nin; v.sv = sv; v.sk = sk; v.st = st;
        v.tl = tl; v.sl = sl; v.kl = kl; v.ns = ns; v.ps = ps; v.pcs = pcs;
        v.err = err; v.win = win;
        return v;
    endfunction

    task automatic do_op(input vec_t v);
        bus.n_ships_in = 3'(v.nin);
        bus.shot_valid = v.sv;
        bus.shot_sunk  = v.sk;
        case (v.op)
            OP_TICK: for (int r = 0; r < v.rep; r++) tick();
            OP_BTN: begin
                bus.btn = 1'b1;
                tick();
                bus.btn = 1'b0;
                tick();
                tick();
            end
            OP_PLC: begin
                bus.place_ok = 1'b1;
                tick();
                bus.place_ok = 1'b0;
            end
            OP_RST: begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag, input vec_t v);
        chk({tag, " flags"},      act_flags(),          exp_flags(v.st));
        chk({tag, " time_left"},  int'(bus.time_left),  v.tl);
        chk({tag, " ships_left"}, int'(bus.ships_left), v.sl);
        chk({tag, " shots_left"}, int'(bus.shots_left), v.kl);
        chk({tag, " n_ships"},    int'(bus.n_ships),    v.ns);
        chk({tag, " p_sunk"},     int'(bus.p_sunk),     v.ps);
        chk({tag, " pc_sunk"},    int'(bus.pc_sunk),    v.pcs);
        chk({tag, " pc_error"},   int'(bus.pc_error),   int'(v.err));
        chk({tag, " winner"},     int'(bus.winner),     int'(v.win));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t rst_exp;

        // op, rep, nin, sv, sk | state, tl, sl, kl, ns, ps, pcs, err, win
        tbl.push_back(mk(OP_BTN,  1, 7, 0, 0, PLACE,   0, 5, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 7, 0, 0, PLACE,   0, 4, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 7, 0, 0, PLACE,   0, 3, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 2, 0, 0, PLACE,   0, 3, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 2, 0, 0, PLACE,   0, 2, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 2, 0, 0, PLACE,   0, 1, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 2, 0, 0, P_TURN,  7, 0, 2, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 7, 2, 0, 0, P_TURN,  0, 0, 2, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_TURN, 0, 0, 2, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 0, PC_CHK,  0, 0, 2, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 0, PC_TURN, 0, 0, 1, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 0, PC_CHK,  0, 0, 1, 5, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 1, P_TURN,  7, 0, 2, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 2, 0, 0, P_CHK,   5, 0, 2, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, P_TURN,  5, 0, 2, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 2, 1, 0, P_CHK,   3, 0, 2, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 0, P_TURN,  3, 0, 1, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 2, 1, 1, P_CHK,   1, 0, 1, 5, 0, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 1, 1, PC_TURN, 1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_CHK,  1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_TURN, 1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_CHK,  1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_TURN, 1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_CHK,  1, 0, 2, 5, 1, 1, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, P_TURN,  7, 0, 2, 5, 1, 1, 1, 0));
        tbl.push_back(mk(OP_TICK, 5, 2, 0, 0, P_TURN,  2, 0, 2, 5, 1, 1, 1, 0));
        tbl.push_back(mk(OP_BTN,  1, 2, 0, 0, P_CHK,   0, 0, 2, 5, 1, 1, 1, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, P_TURN,  0, 0, 2, 5, 1, 1, 1, 0));
        tbl.push_back(mk(OP_TICK, 1, 2, 0, 0, PC_TURN, 0, 0, 2, 5, 1, 1, 1, 0));
        tbl.push_back(mk(OP_RST,  1, 0, 0, 0, SEL,     0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 0, 0, PLACE,   0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 0, 0, 0, P_TURN,  7, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 1, 1, P_CHK,   5, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 0, 1, 1, OVER,    5, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 3, 0, 1, 1, OVER,    5, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 0, 0, SEL,     5, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 0, 0, PLACE,   5, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 0, 0, 0, P_TURN,  7, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 1, 0, P_CHK,   5, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 0, 1, 0, P_TURN,  5, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 0, 1, 0, P_CHK,   3, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 0, 1, 0, PC_TURN, 3, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 0, 1, 1, PC_CHK,  3, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 0, 1, 1, OVER,    3, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(OP_BTN,  1, 0, 0, 0, SEL,     3, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_BTN,  1, 3, 0, 0, PLACE,   3, 3, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 3, 0, 0, PLACE,   3, 2, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 3, 0, 0, PLACE,   3, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(OP_PLC,  1, 3, 0, 0, P_TURN,  7, 0, 2, 3, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 8, 3, 0, 0, PC_TURN, 0, 0, 2, 3, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TICK, 1, 3, 0, 0, PC_CHK,  0, 0, 2, 3, 0, 0, 0, 0));

        rst_exp = mk(OP_RST, 1, 0, 0, 0, SEL, 0, 0, 0, 1, 0, 0, 0, 0);

        bus.btn        = 1'b0;
        bus.n_ships_in = '0;
        bus.place_ok   = 1'b0;
        bus.shot_valid = 1'b0;
        bus.shot_sunk  = 1'b0;

        tick();
        check_state("reset", rst_exp);
        rst_n = 1'b1;
        tick();
        check_state("post_reset", rst_exp);

        foreach (tbl[i]) begin
            do_op(tbl[i]);
            check_state($sformatf("v%0d", i), tbl[i]);
        end

        // Asynchronous reset in the middle of PC_CHK, before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", rst_exp);
        chk("async_rst sel_ships", int'(bus.sel_ships), 1);
        tick();
        check_state("held_rst", rst_exp);
        rst_n = 1'b1;
        tick();
        check_state("rst_release", rst_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
